display_arbiter: RTL and testbench

- Shares the single 4-digit multiplexed 7-segment display between three requesters: 0 = time-of-day, 1 = stopwatch, 2 = alarm notice.
- Fixed priority with a minimum hold time, so the display does not flicker between sources. Optional per-source blinking.
- Drives the four BCD digit inputs (curr_val0..3) of the dynamic display driver, and sits between the mode logic and that driver.

---
 rtl/display_arbiter_pkg.sv | 15 +
 rtl/display_arbiter_if.sv | 22 ++
 rtl/display_arbiter_tick_gen.sv | 15 +
 rtl/display_arbiter.sv | 76 +++++++
 tb/tb_display_arbiter.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/display_arbiter_pkg.sv
// display_arbiter_pkg: shared state encoding, source indices and digit helpers for the display arbiter
package display_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;
  localparam int SRC_CLOCK = 0;
  localparam int SRC_SW = 1;
  localparam int SRC_ALARM = 2;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  // Digits are packed {d3,d2,d1,d0}, so digit i lives at bits 4*i+3:4*i.
  function automatic logic [3:0] digit(input logic [15:0] val, input int i);
    return val[4*i +: 4];
  endfunction
  function automatic logic [2:0] winner(input logic [2:0] req);
    return req[SRC_ALARM] ? 3'b100 : req[SRC_SW] ? 3'b010 : req[SRC_CLOCK] ? 3'b001 : 3'b000;
  endfunction
endpackage

// File: rtl/display_arbiter_if.sv
// display_arbiter_if: request, source digit and display-side signals of the display arbiter
interface display_arbiter_if;
  logic [2:0] req;
  logic [15:0] src0_val;
  logic [15:0] src1_val;
  logic [15:0] src2_val;
  logic [2:0] blink_en;
  logic [2:0] grant;
  logic grant_chg;
  logic [3:0] curr_val0;
  logic [3:0] curr_val1;
  logic [3:0] curr_val2;
  logic [3:0] curr_val3;
  modport master (
    output req, src0_val, src1_val, src2_val, blink_en,
    input grant, grant_chg, curr_val0, curr_val1, curr_val2, curr_val3
  );
  modport slave (
    input req, src0_val, src1_val, src2_val, blink_en,
    output grant, grant_chg, curr_val0, curr_val1, curr_val2, curr_val3
  );
endinterface

// File: rtl/display_arbiter_tick_gen.sv
// tick_gen: free-running divider giving a one-cycle tick every TICK_DIV clocks
module tick_gen #(
  parameter int TICK_DIV = 156250
) (
  input logic clk,
  input logic nRst,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(TICK_DIV - 1);
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) cnt <= '0;
    else cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/display_arbiter.sv
// display_arbiter: priority arbiter with minimum hold and per-source blink for the shared 4-digit display
module display_arbiter #(
  parameter int TICK_DIV = 156250,
  parameter int HOLD_TICKS = 20,
  parameter int BLINK_TICKS = 5,
  parameter logic [3:0] BLANK_CODE = display_arbiter_pkg::BLANK_CODE
) (
  input logic clk,
  input logic nRst,
  display_arbiter_if.slave bus
);
  import display_arbiter_pkg::*;
  localparam int HW = HOLD_TICKS > 0 ? $clog2(HOLD_TICKS + 1) : 1;
  localparam int BW = BLINK_TICKS > 1 ? $clog2(BLINK_TICKS + 1) : 1;
  state_t state, state_n;
  logic [2:0] grant, grant_n, win;
  logic [HW-1:0] hold, hold_n;
  logic [BW-1:0] bcnt, bcnt_n;
  logic phase, phase_n, tick, sw, chg, blank, blink_wrap;
  logic [15:0] digits, sel;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .nRst(nRst), .tick(tick));
  assign win = winner(bus.req);
  assign sel = grant[SRC_ALARM] ? bus.src2_val : grant[SRC_SW] ? bus.src1_val : bus.src0_val;
  assign blank = grant == 3'b000 || (|(bus.blink_en & grant) && phase);
  assign blink_wrap = bcnt == BW'(BLINK_TICKS - 1);
  // During HOLD only the alarm may preempt; losing the current request always re-arbitrates.
  always_comb begin
    sw = state == IDLE ? win != 3'b000 :
         state == HOLD ? (bus.req[SRC_ALARM] && !grant[SRC_ALARM]) || (bus.req & grant) == 3'b000 :
         win != grant;
    state_n = state;
    grant_n = grant;
    hold_n = hold;
    if (sw) begin
      grant_n = win;
      hold_n = HW'(HOLD_TICKS);
      state_n = win == 3'b000 ? IDLE : HOLD;
    end else if (state == HOLD && tick) begin
      hold_n = hold == '0 ? hold : hold - HW'(1);
      state_n = hold <= HW'(1) ? OPEN : HOLD;
    end
    bcnt_n = bcnt;
    phase_n = phase;
    if (grant_n != grant) begin
      bcnt_n = '0;
      phase_n = 1'b0;
    end else if (tick && grant != 3'b000) begin
      bcnt_n = blink_wrap ? '0 : bcnt + BW'(1);
      phase_n = phase ^ blink_wrap;
    end
  end
  always_ff @(posedge clk or negedge nRst)
    if (!nRst) begin
      state <= IDLE;
      grant <= '0;
      chg <= 1'b0;
      hold <= '0;
      bcnt <= '0;
      phase <= 1'b0;
      digits <= {4{BLANK_CODE}};
    end else begin
      state <= state_n;
      grant <= grant_n;
      chg <= grant_n != grant;
      hold <= hold_n;
      bcnt <= bcnt_n;
      phase <= phase_n;
      digits <= blank ? {4{BLANK_CODE}} : sel;
    end
  assign bus.grant = grant;
  assign bus.grant_chg = chg;
  assign bus.curr_val0 = digit(digits, 0);
  assign bus.curr_val1 = digit(digits, 1);
  assign bus.curr_val2 = digit(digits, 2);
  assign bus.curr_val3 = digit(digits, 3);
endmodule

// File: tb/tb_display_arbiter.sv
// tb_display_arbiter: directed table, corner sequences and randomized reference-model check of display_arbiter
module tb_display_arbiter;
  localparam int TD = 4;
  localparam int HT = 5;
  localparam int BT = 2;
  logic clk;
  logic nRst;
  int checks = 0;
  int failures = 0;
  display_arbiter_if bus ();
  display_arbiter #(.TICK_DIV(TD), .HOLD_TICKS(HT), .BLINK_TICKS(BT)) dut (.clk(clk), .nRst(nRst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0] req;
    int n;
    logic [2:0] g;
    logic c;
    logic [15:0] d;
  } vec_t;
  vec_t tbl[12];
  // reference model: owner index (-1 idle) and ticks seen since it was granted
  int m_own;
  int m_tks;
  int m_cyc;
  logic [2:0] e_grant;
  logic e_chg;
  logic [15:0] e_d;
  function automatic logic [15:0] shown();
    return {bus.curr_val3, bus.curr_val2, bus.curr_val1, bus.curr_val0};
  endfunction
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    nRst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_grant", 16'(bus.grant), 16'h0);
    chk("rst_chg", 16'(bus.grant_chg), 16'h0);
    chk("rst_digits", shown(), 16'hFFFF);
    @(negedge clk);
    nRst = 1'b1;
    m_own = -1;
    m_tks = 0;
    m_cyc = 0;
  endtask
  task automatic model_step();
    logic [15:0] s[3];
    int w;
    bit sw;
    bit tick;
    s[0] = bus.src0_val;
    s[1] = bus.src1_val;
    s[2] = bus.src2_val;
    e_d = (m_own < 0 || (bus.blink_en[m_own] && ((m_tks / BT) % 2 == 1))) ? 16'hFFFF : s[m_own];
    w = -1;
    for (int k = 2; k >= 0; k--) if (w < 0 && bus.req[k]) w = k;
    tick = (m_cyc % TD) == TD - 1;
    if (m_own < 0) sw = w >= 0;
    else if (m_tks < HT) sw = (bus.req[2] && m_own != 2) || !bus.req[m_own];
    else sw = w != m_own;
    if (sw) begin
      m_own = w;
      m_tks = 0;
    end else if (tick) m_tks++;
    e_chg = sw;
    e_grant = m_own < 0 ? 3'b000 : 3'(1 << m_own);
    m_cyc++;
  endtask
  initial begin
    nRst = 1'b1;
    bus.req = 3'b001;
    bus.src0_val = 16'h1234;
    bus.src1_val = 16'h5678;
    bus.src2_val = 16'h9ABC;
    bus.blink_en = 3'b000;
    tbl[0] = '{3'b001, 1, 3'b001, 1'b1, 16'hFFFF};
    tbl[1] = '{3'b001, 1, 3'b001, 1'b0, 16'h1234};
    tbl[2] = '{3'b011, 10, 3'b001, 1'b0, 16'h1234};
    tbl[3] = '{3'b011, 8, 3'b001, 1'b0, 16'h1234};
    tbl[4] = '{3'b011, 1, 3'b010, 1'b1, 16'h1234};
    tbl[5] = '{3'b011, 1, 3'b010, 1'b0, 16'h5678};
    tbl[6] = '{3'b111, 1, 3'b100, 1'b1, 16'h5678};
    tbl[7] = '{3'b111, 1, 3'b100, 1'b0, 16'h9ABC};
    tbl[8] = '{3'b011, 1, 3'b010, 1'b1, 16'h9ABC};
    tbl[9] = '{3'b000, 1, 3'b000, 1'b1, 16'h5678};
    tbl[10] = '{3'b000, 1, 3'b000, 1'b0, 16'hFFFF};
    tbl[11] = '{3'b100, 2, 3'b100, 1'b0, 16'h9ABC};
    do_reset();
    foreach (tbl[i]) begin
      bus.req = tbl[i].req;
      repeat (tbl[i].n) @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_grant", i), 16'(bus.grant), 16'(tbl[i].g));
      chk($sformatf("tbl%0d_chg", i), 16'(bus.grant_chg), 16'(tbl[i].c));
      chk($sformatf("tbl%0d_digits", i), shown(), tbl[i].d);
      @(negedge clk);
    end
    // blink on source 1: visible for 2 ticks, blank for 2 ticks
    bus.req = 3'b000;
    bus.blink_en = 3'b010;
    do_reset();
    bus.req = 3'b010;
    for (int e = 1; e <= 17; e++) begin
      @(posedge clk);
      #1;
      if (e == 8 || e == 17) chk($sformatf("blink_vis_e%0d", e), shown(), 16'h5678);
      if (e == 9 || e == 16) chk($sformatf("blink_off_e%0d", e), shown(), 16'hFFFF);
    end
    // asynchronous reset while the alarm is blinking
    @(negedge clk);
    bus.req = 3'b000;
    bus.blink_en = 3'b100;
    do_reset();
    bus.req = 3'b100;
    repeat (17) @(posedge clk);
    #1;
    chk("pre_rst_digits", shown(), 16'h9ABC);
    chk("pre_rst_grant", 16'(bus.grant), 16'h4);
    #2;
    nRst = 1'b0;
    #1;
    chk("async_rst_grant", 16'(bus.grant), 16'h0);
    chk("async_rst_digits", shown(), 16'hFFFF);
    chk("async_rst_chg", 16'(bus.grant_chg), 16'h0);
    // randomized run against the reference model
    bus.req = 3'b000;
    bus.blink_en = 3'b000;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(23) == 0) bus.req = 3'($urandom);
      if ($urandom_range(3) == 0) bus.src0_val = 16'($urandom);
      if ($urandom_range(3) == 0) bus.src1_val = 16'($urandom);
      if ($urandom_range(3) == 0) bus.src2_val = 16'($urandom);
      if ($urandom_range(63) == 0) bus.blink_en = 3'($urandom);
      model_step();
      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_grant", i), 16'(bus.grant), 16'(e_grant));
      chk($sformatf("rnd%0d_chg", i), 16'(bus.grant_chg), 16'(e_chg));
      chk($sformatf("rnd%0d_digits", i), shown(), e_d);
      @(negedge clk);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
